letc_core_stage_memory2: RTL and testbench

- Memory 2 stage of the LETC core pipeline.
- Sits directly downstream of Memory 1, which has already issued the DMSS load address. Sits upstream of Writeback.
- Captures the M1 payload and waits for load data from the DMSS. Aligns and sign- or zero-extends that data.
- Performs the store, and the read-modify-write sequence for AMOs. Forwards the result to Writeback with a valid/ready/stall/flush handshake.

---
 rtl/letc_core_stage_memory2_pkg.sv | 43 ++++
 rtl/letc_core_stage_memory2.sv | 220 ++++++++++++++++++++++
 tb/tb_letc_core_stage_memory2.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/letc_core_stage_memory2_pkg.sv
// rtl/letc_core_stage_memory2_pkg.sv - Payload types shared by the LETC Memory 2 stage and its neighbours
package letc_core_stage_memory2_pkg;

  typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE, MEM_AMO} mem_op_e;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} mem_size_e;
  typedef enum logic [1:0] {RD_SRC_ALU, RD_SRC_MEM, RD_SRC_CSR, RD_SRC_PC4} rd_src_e;
  typedef enum logic [3:0] {
    AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
    AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU
  } amo_op_e;

  typedef struct packed {
    logic [31:0] pc;
    rd_src_e     rd_src;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic        csr_we;
    logic [11:0] csr_idx;
    logic [31:0] alu_result;
    mem_op_e     mem_op;
    logic        mem_signed;
    mem_size_e   mem_size;
    amo_op_e     amo_alu_op;
    logic [31:0] rs2_val;
  } m1_to_m2_s;

  typedef struct packed {
    logic [31:0] pc;
    rd_src_e     rd_src;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic        csr_we;
    logic [11:0] csr_idx;
    logic [31:0] alu_result;
    mem_op_e     mem_op;
    logic        mem_signed;
    mem_size_e   mem_size;
    amo_op_e     amo_alu_op;
    logic [31:0] rs2_val;
    logic [31:0] mem_rdata;
  } m2_to_w_s;

endpackage

// File: rtl/letc_core_stage_memory2.sv
// rtl/letc_core_stage_memory2.sv - LETC Memory 2 stage: load return, store issue, AMO read-modify-write
module letc_core_stage_memory2
  import letc_core_stage_memory2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        m2_ready,
  input  logic        m2_flush,
  input  logic        m2_stall,
  input  logic        m1_to_m2_valid,
  input  m1_to_m2_s   m1_to_m2,
  output logic        m2_to_w_valid,
  output m2_to_w_s    m2_to_w,
  input  logic [31:0] dmss_load_data,
  input  logic        dmss_load_valid,
  output logic        dmss_store_req,
  output logic [31:0] dmss_store_addr,
  output logic [31:0] dmss_store_data,
  output logic [3:0]  dmss_store_be,
  input  logic        dmss_store_ack
);

  // HOLD: memory side finished while stalled; waits to hand off to Writeback
  typedef enum logic [2:0] {IDLE, WAIT_LD, ST, AMO_ST, HOLD} state_e;

  state_e      state, state_n;
  logic        ff_in_valid;
  m1_to_m2_s   ff_in;
  logic [31:0] ld_word;
  logic [31:0] amo_new;
  logic        flushed_q;
  logic        done, leave, ld_take;
  logic [1:0]  off;
  logic [31:0] ld_src;
  logic [31:0] mem_rdata;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input mem_size_e size,
                                               input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
      SIZE_HALF: r = {{16{sgn & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] amo_compute(input amo_op_e op, input logic [31:0] old,
                                              input logic [31:0] src);
    logic [31:0] r;
    case (op)
      AMO_SWAP: r = src;
      AMO_ADD:  r = old + src;
      AMO_AND:  r = old & src;
      AMO_OR:   r = old | src;
      AMO_XOR:  r = old ^ src;
      AMO_MIN:  r = ($signed(old) < $signed(src)) ? old : src;
      AMO_MAX:  r = ($signed(old) > $signed(src)) ? old : src;
      AMO_MINU: r = (old < src) ? old : src;
      AMO_MAXU: r = (old > src) ? old : src;
      default:  r = src;
    endcase
    return r;
  endfunction

  always_comb begin
    state_n        = state;
    done           = 1'b0;
    leave          = 1'b0;
    ld_take        = 1'b0;
    dmss_store_req = 1'b0;
    case (state)
      IDLE: begin
        if (ff_in_valid) begin
          if (m2_flush) begin
            leave = 1'b1;
          end else if (ff_in.mem_op == MEM_NONE) begin
            if (!m2_stall) begin
              done  = 1'b1;
              leave = 1'b1;
            end
          end else if (ff_in.mem_op == MEM_STORE) begin
            state_n = ST;
          end else if (dmss_load_valid) begin
            ld_take = 1'b1;
          end else begin
            state_n = WAIT_LD;
          end
        end
      end
      WAIT_LD: begin
        if (m2_flush) begin
          leave   = 1'b1;
          state_n = IDLE;
        end else if (dmss_load_valid) begin
          ld_take = 1'b1;
        end
      end
      ST, AMO_ST: begin
        // A request already on the bus is never retracted, even when flushed
        dmss_store_req = 1'b1;
        if (dmss_store_ack) begin
          if (flushed_q || m2_flush) begin
            leave   = 1'b1;
            state_n = IDLE;
          end else if (m2_stall) begin
            state_n = HOLD;
          end else begin
            done    = 1'b1;
            leave   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      HOLD: begin
        if (m2_flush) begin
          leave   = 1'b1;
          state_n = IDLE;
        end else if (!m2_stall) begin
          done    = 1'b1;
          leave   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (ld_take) begin
      if (ff_in.mem_op == MEM_AMO) begin
        state_n = AMO_ST;
      end else if (m2_stall) begin
        state_n = HOLD;
      end else begin
        done    = 1'b1;
        leave   = 1'b1;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ff_in_valid <= 1'b0;
      ff_in       <= '0;
      ld_word     <= '0;
      amo_new     <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (!m2_stall && m2_ready) begin
        ff_in_valid <= m1_to_m2_valid;
        ff_in       <= m1_to_m2;
      end else if (leave) begin
        ff_in_valid <= 1'b0;
      end
      if (ld_take) begin
        ld_word <= dmss_load_data;
      end
      if (ld_take && ff_in.mem_op == MEM_AMO) begin
        amo_new <= amo_compute(ff_in.amo_alu_op, dmss_load_data, ff_in.rs2_val);
      end
      flushed_q <= leave ? 1'b0 : (flushed_q | (dmss_store_req & m2_flush));
    end
  end

  assign m2_ready      = !ff_in_valid || leave;
  assign m2_to_w_valid = ff_in_valid && done && !m2_flush && !m2_stall;

  assign off             = ff_in.alu_result[1:0];
  assign dmss_store_addr = {ff_in.alu_result[31:2], 2'b00};

  always_comb begin
    dmss_store_data = ff_in.rs2_val << {off, 3'b000};
    dmss_store_be   = 4'hF;
    if (state == AMO_ST) begin
      dmss_store_data = amo_new;
    end else begin
      case (ff_in.mem_size)
        SIZE_BYTE: dmss_store_be = 4'b0001 << off;
        SIZE_HALF: dmss_store_be = 4'b0011 << off;
        default:   dmss_store_be = 4'hF;
      endcase
    end
  end

  // Once parked in HOLD the bus word has gone; use the latched copy
  assign ld_src = (state == HOLD) ? ld_word : dmss_load_data;

  always_comb begin
    mem_rdata = '0;
    case (ff_in.mem_op)
      MEM_LOAD: mem_rdata = load_extract(ld_src, ff_in.mem_size, ff_in.mem_signed, off);
      MEM_AMO:  mem_rdata = ld_word;
      default:  mem_rdata = '0;
    endcase
  end

  always_comb begin
    m2_to_w            = '0;
    m2_to_w.pc         = ff_in.pc;
    m2_to_w.rd_src     = ff_in.rd_src;
    m2_to_w.rd_idx     = ff_in.rd_idx;
    m2_to_w.rd_we      = ff_in.rd_we;
    m2_to_w.csr_we     = ff_in.csr_we;
    m2_to_w.csr_idx    = ff_in.csr_idx;
    m2_to_w.alu_result = ff_in.alu_result;
    m2_to_w.mem_op     = ff_in.mem_op;
    m2_to_w.mem_signed = ff_in.mem_signed;
    m2_to_w.mem_size   = ff_in.mem_size;
    m2_to_w.amo_alu_op = ff_in.amo_alu_op;
    m2_to_w.rs2_val    = ff_in.rs2_val;
    m2_to_w.mem_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_letc_core_stage_memory2.sv
// tb/tb_letc_core_stage_memory2.sv - Self-checking bench for the LETC Memory 2 stage
module tb_letc_core_stage_memory2;
  import letc_core_stage_memory2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m2_ready;
  logic        m2_flush;
  logic        m2_stall;
  logic        m1_to_m2_valid;
  m1_to_m2_s   m1_to_m2;
  logic        m2_to_w_valid;
  m2_to_w_s    m2_to_w;
  logic [31:0] dmss_load_data;
  logic        dmss_load_valid;
  logic        dmss_store_req;
  logic [31:0] dmss_store_addr;
  logic [31:0] dmss_store_data;
  logic [3:0]  dmss_store_be;
  logic        dmss_store_ack;

  int n_cmp = 0;
  int n_bad = 0;

  letc_core_stage_memory2 dut (
    .clk(clk), .rst_n(rst_n), .m2_ready(m2_ready), .m2_flush(m2_flush), .m2_stall(m2_stall),
    .m1_to_m2_valid(m1_to_m2_valid), .m1_to_m2(m1_to_m2),
    .m2_to_w_valid(m2_to_w_valid), .m2_to_w(m2_to_w),
    .dmss_load_data(dmss_load_data), .dmss_load_valid(dmss_load_valid),
    .dmss_store_req(dmss_store_req), .dmss_store_addr(dmss_store_addr),
    .dmss_store_data(dmss_store_data), .dmss_store_be(dmss_store_be),
    .dmss_store_ack(dmss_store_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input mem_size_e sz,
                                           input bit sgn, input int lane);
    longint unsigned v;
    v = w;
    if (sz == SIZE_BYTE) begin
      v = (v / (64'd1 << (8 * lane))) % 256;
      if (sgn && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == SIZE_HALF) begin
      v = (v / (64'd1 << (16 * (lane / 2)))) % 65536;
      if (sgn && v >= 32768) v = v + 64'hFFFF_0000;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_amo(input amo_op_e op, input logic [31:0] m, input logic [31:0] s);
    int              sm, ss;
    longint unsigned um, us;
    logic [63:0]     sum;
    sm  = m;
    ss  = s;
    um  = m;
    us  = s;
    sum = um + us;
    case (op)
      AMO_ADD:  return sum[31:0];
      AMO_AND:  return m & s;
      AMO_OR:   return m | s;
      AMO_XOR:  return m ^ s;
      AMO_MIN:  return (sm < ss) ? m : s;
      AMO_MAX:  return (sm > ss) ? m : s;
      AMO_MINU: return (um < us) ? m : s;
      AMO_MAXU: return (um > us) ? m : s;
      default:  return s;
    endcase
  endfunction

  task automatic run_txn(input string tag, input mem_op_e op, input mem_size_e sz, input bit sgn,
                         input amo_op_e aop, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] word, input int ld_dly, input int ack_dly,
                         input int flush_at, input int s0, input int s1);
    m1_to_m2_s   p;
    int          lane, nat, exp_cyc, wcnt, wcyc, req_cnt, ready_low;
    logic [31:0] got_rdata, got_pc, got_alu, got_sdata, got_saddr, exp_sdata, junk;
    logic [4:0]  got_rd;
    logic [3:0]  got_be, exp_be;
    logic [63:0] shifted;
    bit          is_ld, is_st, flushed;

    lane    = int'(addr[1:0]);
    is_ld   = (op == MEM_LOAD) || (op == MEM_AMO);
    is_st   = (op == MEM_STORE) || (op == MEM_AMO);
    flushed = (flush_at >= 0);
    case (op)
      MEM_LOAD:  nat = ld_dly;
      MEM_STORE: nat = 1 + ack_dly;
      MEM_AMO:   nat = ld_dly + 1 + ack_dly;
      default:   nat = 0;
    endcase
    exp_cyc = (nat >= s0 && nat < s1) ? s1 : nat;

    p            = '0;
    p.pc         = $urandom;
    p.rd_src     = RD_SRC_MEM;
    p.rd_idx     = 5'($urandom);
    p.rd_we      = 1'b1;
    p.csr_idx    = 12'($urandom);
    p.alu_result = addr;
    p.mem_op     = op;
    p.mem_signed = sgn;
    p.mem_size   = sz;
    p.amo_alu_op = aop;
    p.rs2_val    = rs2;

    @(negedge clk);
    m1_to_m2       = p;
    m1_to_m2_valid = 1'b1;
    #1;
    for (int w = 0; w < 20 && !m2_ready; w++) begin
      @(negedge clk);
      #1;
    end
    check_eq({tag, "/ready_in"}, m2_ready, 1);

    wcnt = 0; wcyc = -1; req_cnt = 0; ready_low = 0;
    got_rdata = '0; got_pc = '0; got_alu = '0; got_rd = '0;
    got_sdata = '0; got_saddr = '0; got_be = '0;
    @(negedge clk);
    m1_to_m2_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      junk            = $urandom;
      m2_flush        = (c == flush_at);
      m2_stall        = (c >= s0) && (c < s1);
      dmss_load_valid = is_ld && (c == ld_dly);
      dmss_load_data  = (c == ld_dly) ? word : junk;
      dmss_store_ack  = dmss_store_req && (req_cnt == ack_dly);
      #1;
      if (dmss_store_req) begin
        req_cnt++;
        got_sdata = dmss_store_data;
        got_saddr = dmss_store_addr;
        got_be    = dmss_store_be;
      end
      if (!m2_ready) ready_low++;
      if (m2_to_w_valid) begin
        wcnt++;
        wcyc      = c;
        got_rdata = m2_to_w.mem_rdata;
        got_pc    = m2_to_w.pc;
        got_alu   = m2_to_w.alu_result;
        got_rd    = m2_to_w.rd_idx;
      end
    end
    check_eq({tag, "/ready_end"}, m2_ready, 1);
    check_eq({tag, "/req_end"}, dmss_store_req, 0);
    m2_flush = 1'b0; m2_stall = 1'b0; dmss_load_valid = 1'b0; dmss_store_ack = 1'b0;

    check_eq({tag, "/w_count"}, wcnt, flushed ? 0 : 1);
    check_eq({tag, "/req_cycles"}, req_cnt, is_st ? ack_dly + 1 : 0);
    if (!flushed) begin
      check_eq({tag, "/w_cycle"}, wcyc, exp_cyc);
      check_eq({tag, "/ready_low"}, ready_low, exp_cyc);
      check_eq({tag, "/pc"}, got_pc, p.pc);
      check_eq({tag, "/rd_idx"}, {27'd0, got_rd}, {27'd0, p.rd_idx});
      check_eq({tag, "/alu"}, got_alu, addr);
      if (op == MEM_LOAD) check_eq({tag, "/rdata"}, got_rdata, ref_load(word, sz, sgn, lane));
      if (op == MEM_AMO)  check_eq({tag, "/rdata"}, got_rdata, word);
    end
    if (is_st) begin
      if (op == MEM_AMO) begin
        exp_sdata = ref_amo(aop, word, rs2);
        exp_be    = 4'hF;
      end else begin
        shifted   = {32'd0, rs2} * (64'd1 << (8 * lane));
        exp_sdata = shifted[31:0];
        exp_be    = (sz == SIZE_BYTE) ? 4'(1 << lane) : (sz == SIZE_HALF) ? 4'(3 << lane) : 4'hF;
      end
      check_eq({tag, "/st_data"}, got_sdata, exp_sdata);
      check_eq({tag, "/st_be"}, {28'd0, got_be}, {28'd0, exp_be});
      check_eq({tag, "/st_addr"}, got_saddr, addr & 32'hFFFF_FFFC);
    end
  endtask

  task automatic reset_mid_amo();
    m1_to_m2_s p;
    p            = '0;
    p.alu_result = 32'h0000_8000;
    p.mem_op     = MEM_AMO;
    p.mem_size   = SIZE_WORD;
    p.amo_alu_op = AMO_ADD;
    p.rs2_val    = 32'd7;
    @(negedge clk);
    m1_to_m2       = p;
    m1_to_m2_valid = 1'b1;
    @(negedge clk);
    m1_to_m2_valid  = 1'b0;
    dmss_load_valid = 1'b1;
    dmss_load_data  = 32'd5;
    @(negedge clk);
    dmss_load_valid = 1'b0;
    #1;
    check_eq("rst_amo/req_before", dmss_store_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_amo/req_after", dmss_store_req, 0);
    check_eq("rst_amo/w_valid", m2_to_w_valid, 0);
    check_eq("rst_amo/ready", m2_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_op_e     op;
    mem_size_e   sz;
    amo_op_e     aop;
    logic [31:0] a;
    int          lane, s0, s1;

    rst_n = 1'b0; m2_flush = 1'b0; m2_stall = 1'b0; m1_to_m2_valid = 1'b0; m1_to_m2 = '0;
    dmss_load_data = '0; dmss_load_valid = 1'b0; dmss_store_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset/w_valid", m2_to_w_valid, 0);
    check_eq("reset/req", dmss_store_req, 0);
    check_eq("reset/ready", m2_ready, 1);
    rst_n = 1'b1;

    run_txn("ld_b_s",   MEM_LOAD,  SIZE_BYTE, 1, AMO_SWAP, 32'h1003, 0, 32'h80FF_1234, 0, 0, -1, 0, 0);
    run_txn("ld_h_u",   MEM_LOAD,  SIZE_HALF, 0, AMO_SWAP, 32'h2002, 0, 32'hBEEF_0001, 3, 0, -1, 0, 0);
    run_txn("st_b",     MEM_STORE, SIZE_BYTE, 0, AMO_SWAP, 32'h3001, 32'hAB, 0, 0, 2, -1, 0, 0);
    run_txn("amomaxu",  MEM_AMO,   SIZE_WORD, 0, AMO_MAXU, 32'h4000, 32'hFFFF_FFFF, 32'h5, 1, 1, -1, 0, 0);
    run_txn("amomin",   MEM_AMO,   SIZE_WORD, 0, AMO_MIN,  32'h4004, 32'hFFFF_FFFF, 32'h5, 0, 0, -1, 0, 0);
    run_txn("fl_wait",  MEM_LOAD,  SIZE_WORD, 0, AMO_SWAP, 32'h5000, 0, 32'h1111_2222, 4, 0, 2, 0, 0);
    run_txn("after_fl", MEM_LOAD,  SIZE_WORD, 0, AMO_SWAP, 32'h5004, 0, 32'h3333_4444, 1, 0, -1, 0, 0);
    run_txn("fl_st",    MEM_STORE, SIZE_HALF, 0, AMO_SWAP, 32'h6002, 32'h1234, 0, 0, 2, 1, 0, 0);
    run_txn("stall_ld", MEM_LOAD,  SIZE_BYTE, 1, AMO_SWAP, 32'h7001, 0, 32'h0000_F000, 0, 0, -1, 0, 3);
    run_txn("stall_st", MEM_STORE, SIZE_WORD, 0, AMO_SWAP, 32'h7100, 32'hCAFE_F00D, 0, 0, 1, -1, 1, 4);
    reset_mid_amo();
    run_txn("after_rst", MEM_NONE, SIZE_WORD, 0, AMO_SWAP, 32'h9000, 0, 0, 0, 0, -1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op  = mem_op_e'($urandom_range(0, 3));
      sz  = mem_size_e'($urandom_range(0, 2));
      aop = amo_op_e'($urandom_range(0, 8));
      if (op == MEM_AMO) sz = SIZE_WORD;
      lane = (sz == SIZE_BYTE) ? int'($urandom_range(0, 3)) :
             (sz == SIZE_HALF) ? 2 * int'($urandom_range(0, 1)) : 0;
      a = $urandom;
      a = {a[31:2], 2'(lane)};
      if ($urandom_range(0, 1) == 1) begin
        s0 = int'($urandom_range(0, 5));
        s1 = s0 + int'($urandom_range(1, 3));
      end else begin
        s0 = 0;
        s1 = 0;
      end
      run_txn($sformatf("rnd%0d", i), op, sz, 1'($urandom), aop, a, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, s0, s1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
